data_mem_bytelane: RTL and testbench
====================================

# data_mem_bytelane

Parametrised data memory with byte/halfword/word access for the single-cycle/multi-cycle core datapath. It sits on the load/store path behind the ALU address output and supports little-endian byte lanes, sign/zero-extended loads, and a registered read with a valid strobe. It also clears itself after reset and flags misaligned or out-of-range accesses. It replaces the fixed 32-bit, word-only data store.

## Interface

- DEPTH, 64, number of 32-bit words; power of two, ≥ 2
- ADDR_W, 32, byte-address width
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- req  in  1  access request, sampled when ready=1
- writeEnable  in  1  1 = store, 0 = load; qualified by req
- size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- unsignedLoad  in  1  1 = zero-extend a byte/half load, 0 = sign-extend
- addr  in  ADDR_W  byte address
- writeData  in  32  store data, right-justified (byte in [7:0], half in [15:0])
- ready  out  1  memory accepts requests
- readData  out  32  extended load result
- readValid  out  1  one-cycle strobe, readData valid
- fault  out  1  one-cycle strobe, the accepted access was illegal

## Operation

- The block is always in one of two states, CLEAR or RUN. `reset` forces CLEAR and sets clear index=0, ready=0, readValid=0, fault=0, readData=0.
- CLEAR: each cycle writes 0 to word[index] and increments the index. After word DEPTH-1 is written, the next state is RUN and ready=1. This takes exactly DEPTH cycles. `req` is ignored in CLEAR. Reset asserted during CLEAR restarts the sequence from index 0.
- RUN: an access is accepted on any rising edge where req=1. ready stays 1, and there is no backpressure.
- Decode:
  - word index = addr[log2(DEPTH)+1:2]
  - byte offset = addr[1:0]
- An access is illegal if any of these hold:
  - size=11
  - half with addr[0]=1
  - word with addr[1:0]≠0
  - any addr bit at or above position log2(DEPTH)+2 is 1 (out of range)
- Illegal access:
  - No array write.
  - fault=1 in the following cycle.
  - For a load, readValid=1 and readData=0 in that same cycle.
- Store, little-endian lanes:
  - byte at offset k writes bits [8k+7:8k] from writeData[7:0]
  - half at offset 0 writes [15:0], at offset 2 writes [31:16], from writeData[15:0]
  - word writes all 32 bits
  - Other lanes are unchanged.
- Load:
  - Select the same lane as a store.
  - Extend to 32 bits with the lane MSB, or with 0 if unsignedLoad=1.
  - The word size ignores unsignedLoad.
- Stores never assert readValid.
- A legal access leaves fault=0.

## Timing

- Store: the array updates on the accepting edge.
- Load latency is 1 cycle. readData/readValid are registered on the accepting edge and are visible for exactly the next cycle.
- readData holds its last value when readValid=0.
- Throughput is one access per cycle, and loads and stores may interleave freely.
- Store at edge N followed by a load of the same word at edge N+1 returns the new data (write-before-read ordering across edges).
- Reset mid-operation: a pending readValid/fault is dropped. Both outputs are 0 in the cycle after the reset edge, and memory is re-cleared.
- After reset deasserts, ready=1 on cycle DEPTH. For DEPTH=64, the first request can be accepted on edge 64.

## Test plan

- Reset, then hold reset low → ready=0 for 64 cycles, then 1. A word load from every address 0x00..0xFC returns 0, with readValid one cycle after each req.
- Store word 0xDEADBEEF @0x10, then load byte @0x13 signed → 0xFFFFFFDE. Byte @0x12 unsigned → 0x000000AD. Half @0x10 signed → 0xFFFFBEEF. Half @0x12 unsigned → 0x0000DEAD.
- Store byte 0x5A @0x21 over word 0x11223344 @0x20 → word load returns 0x11225A44. Store half 0x7788 @0x22 → 0x77885A44.
- Back-to-back: store 0x00000007 @0x04 at edge N, load word @0x04 at edge N+1 → readData=7 at N+2. Then issue 4 consecutive loads → 4 consecutive readValid pulses.
- Illegal accesses:
  - Half load @0x01 → fault=1, readValid=1, readData=0.
  - Word store @0x06 → fault=1, memory unchanged.
  - Word load @0x100 (DEPTH=64) → fault=1.
  - size=11 → fault=1.
- Reset asserted in the cycle after a load is accepted → readValid=0 and fault=0 in the following cycle. Full CLEAR repeats, and previously stored data reads as 0.

Source files
------------

// File: rtl/data_mem_bytelane.sv
// Byte/halfword/word data memory with little-endian lanes, extended registered loads,
// self-clear after reset, and a fault strobe for misaligned or out-of-range accesses.
module data_mem_bytelane #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              writeEnable,
  input  logic [1:0]        size,
  input  logic              unsignedLoad,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       writeData,
  output logic              ready,
  output logic [31:0]       readData,
  output logic              readValid,
  output logic              fault
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t           state, state_next;
  logic [IDX_W-1:0] clr_idx, clr_idx_next;
  logic [31:0]      mem [DEPTH];

  logic [IDX_W-1:0] word_idx;
  logic [1:0]       offset;
  logic             out_of_range;
  logic             illegal;
  logic             accept;
  logic [3:0]       lane_en;
  logic [31:0]      store_data;

  function automatic logic [3:0] lane_mask(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      2'b00:   lane_mask = 4'b0001 << off;
      2'b01:   lane_mask = 4'b0011 << off;
      2'b10:   lane_mask = 4'b1111;
      default: lane_mask = 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] extend_load(input logic [31:0] word, input logic [1:0] sz,
                                              input logic [1:0] off, input logic uns);
    logic [31:0]        shifted;
    logic signed [7:0]  lane_b;
    logic signed [15:0] lane_h;
    shifted = word >> {off, 3'b000};
    lane_b  = shifted[7:0];
    lane_h  = shifted[15:0];
    case (sz)
      2'b00:   extend_load = uns ? {24'd0, lane_b} : 32'(lane_b);
      2'b01:   extend_load = uns ? {16'd0, lane_h} : 32'(lane_h);
      default: extend_load = word;
    endcase
  endfunction

  assign word_idx = addr[IDX_W+1:2];
  assign offset   = addr[1:0];

  generate
    if (ADDR_W > IDX_W + 2) begin : g_range
      assign out_of_range = |addr[ADDR_W-1:IDX_W+2];
    end else begin : g_no_range
      assign out_of_range = 1'b0;
    end
  endgenerate

  assign illegal = (size == 2'b11) || (size == 2'b01 && addr[0]) ||
                   (size == 2'b10 && offset != 2'b00) || out_of_range;
  assign lane_en = lane_mask(size, offset);

  // Right-justified store data is replicated so every lane sees its own copy.
  always_comb begin
    case (size)
      2'b00:   store_data = {4{writeData[7:0]}};
      2'b01:   store_data = {2{writeData[15:0]}};
      default: store_data = writeData;
    endcase
  end

  always_comb begin
    state_next   = state;
    clr_idx_next = clr_idx;
    ready        = 1'b0;
    case (state)
      CLEAR: begin
        clr_idx_next = clr_idx + 1'b1;
        if (clr_idx == IDX_W'(DEPTH - 1)) state_next = RUN;
      end
      RUN: ready = 1'b1;
      default: state_next = CLEAR;
    endcase
  end

  assign accept = ready & req;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= CLEAR;
      clr_idx <= '0;
    end else begin
      state   <= state_next;
      clr_idx <= clr_idx_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == CLEAR) begin
        mem[clr_idx] <= '0;
      end else if (accept && writeEnable && !illegal) begin
        for (int b = 0; b < 4; b++) begin
          if (lane_en[b]) mem[word_idx][8*b +: 8] <= store_data[8*b +: 8];
        end
      end
    end
  end

  // Load result stage: one-cycle strobes, readData holds between loads.
  always_ff @(posedge clk) begin
    if (reset) begin
      readValid <= 1'b0;
      fault     <= 1'b0;
      readData  <= '0;
    end else begin
      readValid <= accept && !writeEnable;
      fault     <= accept && illegal;
      if (accept && !writeEnable) begin
        readData <= illegal ? 32'd0 : extend_load(mem[word_idx], size, offset, unsignedLoad);
      end
    end
  end

endmodule

// File: tb/tb_data_mem_bytelane.sv
// Directed and randomized checks of data_mem_bytelane against a byte-array reference model.
module tb_data_mem_bytelane;
  localparam int DEPTH  = 64;
  localparam int ADDR_W = 32;
  localparam int NBYTES = DEPTH * 4;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              req = 1'b0;
  logic              writeEnable = 1'b0;
  logic [1:0]        size = 2'b10;
  logic              unsignedLoad = 1'b0;
  logic [ADDR_W-1:0] addr = '0;
  logic [31:0]       writeData = '0;
  logic              ready;
  logic [31:0]       readData;
  logic              readValid;
  logic              fault;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [7:0]  mb [NBYTES];
  logic [31:0] last_rd = '0;

  always #5 clk = ~clk;

  data_mem_bytelane #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .req(req), .writeEnable(writeEnable), .size(size),
    .unsignedLoad(unsignedLoad), .addr(addr), .writeData(writeData), .ready(ready),
    .readData(readData), .readValid(readValid), .fault(fault)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < NBYTES; i++) mb[i] = 8'h00;
    last_rd = '0;
  endtask

  // Byte-addressed little-endian reference: value = sum of bytes << 8*i.
  task automatic model(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic erv, output logic [31:0] erd, output logic ef);
    int          n;
    logic [31:0] v;
    bit          bad;
    bad = (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0) ||
          (a >= NBYTES);
    ef  = bad;
    erv = !we;
    erd = last_rd;
    if (bad) begin
      if (!we) erd = 32'd0;
    end else begin
      n = 1 << sz;
      if (we) begin
        for (int i = 0; i < n; i++) mb[int'(a) + i] = wd[8*i +: 8];
      end else begin
        v = 32'd0;
        for (int i = 0; i < n; i++) v = v + (32'(mb[int'(a) + i]) << (8 * i));
        if (!uns && n < 4 && v[8*n-1]) v = v - (32'd1 << (8 * n));
        erd = v;
      end
    end
    last_rd = erd;
  endtask

  task automatic access(input string tag, input logic we, input logic [1:0] sz,
                        input logic uns, input logic [31:0] a, input logic [31:0] wd);
    logic        erv, ef;
    logic [31:0] erd;
    chk({tag, "_ready"}, 32'(ready), 32'd1);
    req = 1'b1; writeEnable = we; size = sz; unsignedLoad = uns; addr = a; writeData = wd;
    tick();
    model(we, sz, uns, a, wd, erv, erd, ef);
    chk({tag, "_valid"}, 32'(readValid), 32'(erv));
    chk({tag, "_fault"}, 32'(fault), 32'(ef));
    chk({tag, "_data"}, readData, erd);
  endtask

  task automatic idle(input string tag);
    req = 1'b0;
    tick();
    chk({tag, "_idle_valid"}, 32'(readValid), 32'd0);
    chk({tag, "_idle_fault"}, 32'(fault), 32'd0);
    chk({tag, "_idle_data"}, readData, last_rd);
  endtask

  // Requests driven during reset and CLEAR must be ignored.
  task automatic reset_and_clear(input string tag);
    int cnt;
    reset = 1'b1; req = 1'b1; writeEnable = 1'b1; size = 2'b10; addr = '0;
    writeData = 32'hFFFF_FFFF;
    tick();
    chk({tag, "_rst_ready"}, 32'(ready), 32'd0);
    chk({tag, "_rst_valid"}, 32'(readValid), 32'd0);
    chk({tag, "_rst_fault"}, 32'(fault), 32'd0);
    chk({tag, "_rst_data"}, readData, 32'd0);
    reset = 1'b0;
    cnt = 0;
    while (ready !== 1'b1 && cnt < 200) begin
      tick();
      cnt++;
    end
    chk({tag, "_clear_cycles"}, 32'(cnt), 32'd64);
    req = 1'b0;
    clear_model();
  endtask

  initial begin
    logic [31:0] a;
    logic [1:0]  sz;

    reset_and_clear("init");

    for (int w = 0; w < DEPTH; w++) access("zero_ld", 1'b0, 2'd2, 1'b0, 32'(w * 4), 32'd0);
    idle("zero");

    access("st_deadbeef", 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF);
    access("ld_b13s", 1'b0, 2'd0, 1'b0, 32'h13, 32'd0);
    chk("const_b13s", readData, 32'hFFFF_FFDE);
    access("ld_b12u", 1'b0, 2'd0, 1'b1, 32'h12, 32'd0);
    chk("const_b12u", readData, 32'h0000_00AD);
    access("ld_h10s", 1'b0, 2'd1, 1'b0, 32'h10, 32'd0);
    chk("const_h10s", readData, 32'hFFFF_BEEF);
    access("ld_h12u", 1'b0, 2'd1, 1'b1, 32'h12, 32'd0);
    chk("const_h12u", readData, 32'h0000_DEAD);
    idle("lanes");

    access("st_w20", 1'b1, 2'd2, 1'b0, 32'h20, 32'h1122_3344);
    access("st_b21", 1'b1, 2'd0, 1'b0, 32'h21, 32'hFFFF_FF5A);
    access("ld_w20a", 1'b0, 2'd2, 1'b1, 32'h20, 32'd0);
    chk("const_w20a", readData, 32'h1122_5A44);
    access("st_h22", 1'b1, 2'd1, 1'b0, 32'h22, 32'hAAAA_7788);
    access("ld_w20b", 1'b0, 2'd2, 1'b0, 32'h20, 32'd0);
    chk("const_w20b", readData, 32'h7788_5A44);

    access("st_w04", 1'b1, 2'd2, 1'b0, 32'h04, 32'h0000_0007);
    access("ld_w04", 1'b0, 2'd2, 1'b0, 32'h04, 32'd0);
    chk("const_w04", readData, 32'd7);
    for (int i = 0; i < 4; i++) access("b2b_ld", 1'b0, 2'd2, 1'b0, 32'(i * 4 + 16), 32'd0);
    idle("b2b");

    access("ill_h01", 1'b0, 2'd1, 1'b0, 32'h01, 32'd0);
    access("ill_st06", 1'b1, 2'd2, 1'b0, 32'h06, 32'hCAFE_F00D);
    access("chk_w04", 1'b0, 2'd2, 1'b0, 32'h04, 32'd0);
    access("ill_ld100", 1'b0, 2'd2, 1'b0, 32'h100, 32'd0);
    access("ill_sz3", 1'b0, 2'd3, 1'b0, 32'h08, 32'd0);
    access("ill_st_sz3", 1'b1, 2'd3, 1'b0, 32'h08, 32'h1234_5678);
    access("chk_w08", 1'b0, 2'd2, 1'b0, 32'h08, 32'd0);
    idle("illegal");

    for (int i = 0; i < 400; i++) begin
      sz = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a = $urandom;
      else a = 32'($urandom_range(0, NBYTES - 1));
      if ($urandom_range(0, 3) != 0 && sz != 2'd3) a = a & ~((32'd1 << sz) - 32'd1);
      access("rand", 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
      if ($urandom_range(0, 9) == 0) idle("rand");
    end
    idle("rand_end");

    access("pre_rst_st", 1'b1, 2'd2, 1'b0, 32'h30, 32'h89AB_CDEF);
    access("pre_rst_ld", 1'b0, 2'd2, 1'b0, 32'h30, 32'd0);
    reset_and_clear("rst_after_ld");
    access("post_rst_ld30", 1'b0, 2'd2, 1'b0, 32'h30, 32'd0);
    access("post_rst_ld00", 1'b0, 2'd2, 1'b0, 32'h00, 32'd0);
    access("pre_rst_ill", 1'b0, 2'd1, 1'b0, 32'h03, 32'd0);
    reset_and_clear("rst_after_fault");

    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    reset_and_clear("rst_in_clear");
    access("final_ld", 1'b0, 2'd2, 1'b0, 32'h00, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
